frame_buf_writer_rgb888: RTL and testbench

//  Write-back end of the 3x3 filter pipeline: takes the raster-ordered filtered pixel stream
//  (valid-qualified, one pixel per cycle, no backpressure upstream) and writes it into the

---
 rtl/frame_buf_writer_rgb888_pkg.sv | 28 ++
 rtl/frame_buf_writer_rgb888_if.sv | 32 +++
 rtl/frame_buf_writer_rgb888_fifo.sv | 68 ++++++
 rtl/frame_buf_writer_rgb888.sv | 144 ++++++++++++++
 tb/tb_frame_buf_writer_rgb888.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buf_writer_rgb888_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : frame_buf_writer_rgb888_pkg
//  Purpose : Shared image-pipeline defaults and the writer state encoding.
//  Contents: default frame geometry and bus widths, writer FSM state type,
//            frame pixel-count helper.
//  Rev     : 1.0  initial release
// ============================================================================
package frame_buf_writer_rgb888_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 17;
    localparam int DEF_WIDTH  = 480;
    localparam int DEF_HEIGHT = 272;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    function automatic int frame_pix(input int width, input int height);
        return width * height;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buf_writer_rgb888_if.sv
`default_nettype none
// ============================================================================
//  Interfaces : frame_buf_writer_rgb888_pix_if, frame_buf_writer_rgb888_bram_if
//  Purpose    : Pixel stream into the writer and the BRAM write port out of it.
//  pix_if     : valid, pixel (producer -> writer), ready (status back)
//  bram_if    : we, addr, wdata (writer -> BRAM), wr_ready (grant back)
//  Rev        : 1.0  initial release
// ============================================================================
interface frame_buf_writer_rgb888_pix_if
    import frame_buf_writer_rgb888_pkg::*;
    #(parameter int DATA_W = DEF_DATA_W);
    logic              valid;
    logic [DATA_W-1:0] pixel;
    logic              ready;

    modport master (output valid, output pixel, input  ready);
    modport slave  (input  valid, input  pixel, output ready);
endinterface

interface frame_buf_writer_rgb888_bram_if
    import frame_buf_writer_rgb888_pkg::*;
    #(parameter int DATA_W = DEF_DATA_W,
      parameter int ADDR_W = DEF_ADDR_W);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_ready;

    modport master (output we, output addr, output wdata, input  wr_ready);
    modport slave  (input  we, input  addr, input  wdata, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/frame_buf_writer_rgb888_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : pixel_sync_fifo
//  Purpose : Small synchronous skid FIFO; push while full is accepted when a
//            pop happens on the same edge.
//  Ports   : iClk, iRst (async, active-low), iPush, iPop, iData,
//            oData (head, show-ahead), oFull, oEmpty
//  Rev     : 1.0  initial release
// ============================================================================
module pixel_sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  wire logic         iClk,
    input  wire logic         iRst,
    input  wire logic         iPush,
    input  wire logic         iPop,
    input  wire logic [W-1:0] iData,
    output logic      [W-1:0] oData,
    output logic              oFull,
    output logic              oEmpty
);
    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_depth_chk
            $error("pixel_sync_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]   mem_q [DEPTH];
    logic           w_push;
    logic           w_pop;

    assign oEmpty = (wr_ptr_q == rd_ptr_q);
    assign oFull  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign w_pop  = iPop & ~oEmpty;
    assign w_push = iPush & (~oFull | w_pop);
    assign oData  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge iClk) begin
        if (w_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= iData;
    end

endmodule
`default_nettype wire

// File: rtl/frame_buf_writer_rgb888.sv
`default_nettype none
// ============================================================================
//  Module  : frame_buf_writer_rgb888
//  Purpose : Writes a raster-ordered filtered pixel stream into the result
//            frame BRAM through a skid FIFO; flags frame completion and drops.
//  Ports   : iClk, iRst (async, active-low), iEn, iStart, iClrErr,
//            pix  (slave)  : valid/pixel in, ready out (FIFO not full)
//            bram (master) : registered we/addr/wdata out, wr_ready in
//            oBusy, oFrameDone, oOverflow
//  Rev     : 1.0  initial release
// ============================================================================
module frame_buf_writer_rgb888
    import frame_buf_writer_rgb888_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int DEPTH      = 130560,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                   iClk,
    input  wire logic                   iRst,
    input  wire logic                   iEn,
    input  wire logic                   iStart,
    input  wire logic                   iClrErr,
    frame_buf_writer_rgb888_pix_if.slave  pix,
    frame_buf_writer_rgb888_bram_if.master bram,
    output logic                        oBusy,
    output logic                        oFrameDone,
    output logic                        oOverflow
);
    localparam int FRAME_PIX = frame_pix(WIDTH, HEIGHT);
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);
    localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);

    generate
        if (DEPTH < BASE_ADDR + FRAME_PIX) begin : g_depth_chk
            $error("frame_buf_writer_rgb888: frame does not fit in BRAM");
        end
    endgenerate

    wr_state_e         state_q,  state_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              ovf_q,    ovf_d;

    // Each FIFO entry carries its raster index so that a dropped pixel leaves
    // a hole at its own address instead of shifting later pixels down.
    logic [CNT_W+DATA_W-1:0] w_head;
    logic [CNT_W-1:0]        w_head_idx;
    logic [DATA_W-1:0]       w_head_pix;
    logic w_full, w_empty;
    logic w_pop, w_take, w_push, w_drop_full, w_drop_out;

    assign w_pop       = iEn & bram.wr_ready & ~w_empty;
    assign w_take      = iEn & pix.valid & (state_q == ST_WRITE);
    assign w_push      = w_take & (~w_full | w_pop);
    assign w_drop_full = w_take & w_full & ~w_pop;
    assign w_drop_out  = iEn & pix.valid & (state_q != ST_WRITE);
    assign {w_head_idx, w_head_pix} = w_head;

    pixel_sync_fifo #(
        .W     (CNT_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (w_push),
        .iPop   (w_pop),
        .iData  ({in_cnt_q, pix.pixel}),
        .oData  (w_head),
        .oFull  (w_full),
        .oEmpty (w_empty)
    );

    always_comb begin
        state_d  = state_q;
        in_cnt_d = in_cnt_q;
        wr_cnt_d = wr_cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ovf_d    = ovf_q;
        if (iEn) begin
            ovf_d    = (ovf_q & ~iClrErr) | w_drop_full | w_drop_out;
            in_cnt_d = in_cnt_q + CNT_W'(w_take);
            // Write count retires both written and dropped pixels, so the
            // frame still completes when pixels were lost.
            wr_cnt_d = wr_cnt_q + CNT_W'(w_pop) + CNT_W'(w_drop_full);
            if (w_pop) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(w_head_idx);
                wdata_d = w_head_pix;
            end
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        state_d  = ST_WRITE;
                        in_cnt_d = '0;
                        wr_cnt_d = '0;
                    end
                end
                ST_WRITE: if (in_cnt_d == FRAME_PIX_C) state_d = ST_DRAIN;
                ST_DRAIN: if (w_empty && wr_cnt_q == FRAME_PIX_C) state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= ST_IDLE;
            in_cnt_q <= '0;
            wr_cnt_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pix.ready  = ~w_full;
    assign bram.we    = we_q;
    assign bram.addr  = addr_q;
    assign bram.wdata = wdata_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oFrameDone = (state_q == ST_DONE);
    assign oOverflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_writer_rgb888.sv
`default_nettype none
// ============================================================================
//  Module  : tb_frame_buf_writer_rgb888
//  Purpose : Directed self-checking bench for frame_buf_writer_rgb888 with a
//            4x3 frame; a second instance at base address 0x100 receives the
//            same stimulus.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_frame_buf_writer_rgb888;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        clr_err = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] pixel = '0;
    logic        wr_ready = 1'b1;

    logic a_busy, a_fd, a_ovf;
    logic b_busy, b_fd, b_ovf;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_buf_writer_rgb888_pix_if  #(.DATA_W(24))              a_pix ();
    frame_buf_writer_rgb888_bram_if #(.DATA_W(24), .ADDR_W(17)) a_bram ();
    frame_buf_writer_rgb888_pix_if  #(.DATA_W(24))              b_pix ();
    frame_buf_writer_rgb888_bram_if #(.DATA_W(24), .ADDR_W(17)) b_bram ();

    assign a_pix.valid     = valid;
    assign a_pix.pixel     = pixel;
    assign a_bram.wr_ready = wr_ready;
    assign b_pix.valid     = valid;
    assign b_pix.pixel     = pixel;
    assign b_bram.wr_ready = wr_ready;

    frame_buf_writer_rgb888 #(
        .DATA_W(24), .ADDR_W(17), .WIDTH(4), .HEIGHT(3),
        .DEPTH(130560), .BASE_ADDR(0), .FIFO_DEPTH(4)
    ) dut_a (
        .iClk(clk), .iRst(rst_n), .iEn(en), .iStart(start), .iClrErr(clr_err),
        .pix(a_pix.slave), .bram(a_bram.master),
        .oBusy(a_busy), .oFrameDone(a_fd), .oOverflow(a_ovf)
    );

    frame_buf_writer_rgb888 #(
        .DATA_W(24), .ADDR_W(17), .WIDTH(4), .HEIGHT(3),
        .DEPTH(130560), .BASE_ADDR(32'h100), .FIFO_DEPTH(4)
    ) dut_b (
        .iClk(clk), .iRst(rst_n), .iEn(en), .iStart(start), .iClrErr(clr_err),
        .pix(b_pix.slave), .bram(b_bram.master),
        .oBusy(b_busy), .oFrameDone(b_fd), .oOverflow(b_ovf)
    );

    // Write monitors: log every BRAM write and any address outside the frame.
    int a_addr[$];
    int a_data[$];
    int a_cyc[$];
    int a_done = 0;
    int a_bad  = 0;
    int b_addr[$];
    int b_data[$];
    int b_bad  = 0;

    always @(negedge clk) begin
        if (a_bram.we === 1'b1) begin
            a_addr.push_back(int'(a_bram.addr));
            a_data.push_back(int'(a_bram.wdata));
            a_cyc.push_back(cyc);
            if (a_bram.addr > 17'd11) a_bad = a_bad + 1;
        end
        if (a_fd === 1'b1) a_done = a_done + 1;
        if (b_bram.we === 1'b1) begin
            b_addr.push_back(int'(b_bram.addr));
            b_data.push_back(int'(b_bram.wdata));
            if (b_bram.addr < 17'h100 || b_bram.addr > 17'h10B) b_bad = b_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        a_addr.delete(); a_data.delete(); a_cyc.delete();
        b_addr.delete(); b_data.delete();
        a_done = 0;
    endtask

    task automatic start_frame();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_run(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            pixel = 24'(first + i);
            step();
        end
        valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 40 && a_done < target; i++) step();
        check(tag, a_done, target);
    endtask

    task automatic check_frame(input string tag, input int first_idx, input int first_pix);
        for (int i = first_idx; i < 12 && i < a_addr.size(); i++) begin
            check({tag, "_addr"}, a_addr[i], i);
            check({tag, "_data"}, a_data[i], first_pix + i - first_idx);
        end
    endtask

    initial begin
        int c0;
        int hits;

        // Reset state
        rst_n = 1'b0;
        step(); step();
        check("rst_we",    {31'd0, a_bram.we}, 0);
        check("rst_addr",  a_bram.addr, 0);
        check("rst_wdata", a_bram.wdata, 0);
        check("rst_flags", {a_busy, a_fd, a_ovf, a_pix.ready}, 4'b0001);
        rst_n = 1'b1;
        step();

        // 1: back-to-back frame, BRAM always granted
        clear_log();
        start_frame();
        c0 = cyc;
        send_run(1, 12);
        wait_done("t1_done", 1);
        check("t1_count", a_addr.size(), 12);
        if (a_cyc.size() > 0) check("t1_latency", a_cyc[0], c0 + 2);
        check_frame("t1", 0, 1);
        check("t1_ovf", a_ovf, 0);
        step();
        check("t1_idle", a_busy, 0);

        // 2: BRAM not granted while FIFO fills exactly
        clear_log();
        start_frame();
        wr_ready = 1'b0;
        send_run(1, 4);
        check("t2_ready_full", a_pix.ready, 0);
        check("t2_no_write", a_addr.size(), 0);
        wr_ready = 1'b1;
        step(); step(); step(); step();
        check("t2_burst", a_addr.size(), 4);
        if (a_cyc.size() >= 4) check("t2_consec", a_cyc[3] - a_cyc[0], 3);
        send_run(5, 8);
        wait_done("t2_done", 1);
        check_frame("t2", 0, 1);
        check("t2_ovf", a_ovf, 0);

        // 3: fifth pixel dropped while FIFO full
        clear_log();
        start_frame();
        wr_ready = 1'b0;
        send_run(1, 5);
        check("t3_ovf_set", a_ovf, 1);
        wr_ready = 1'b1;
        send_run(6, 7);
        wait_done("t3_done", 1);
        check("t3_count", a_addr.size(), 11);
        hits = 0;
        foreach (a_addr[i]) if (a_addr[i] == 4) hits++;
        check("t3_hole", hits, 0);
        if (a_addr.size() == 11) begin
            check("t3_addr5", a_addr[4], 5);
            check("t3_data5", a_data[4], 6);
            check("t3_addr11", a_addr[10], 11);
            check("t3_data11", a_data[10], 12);
        end
        check("t3_ovf_sticky", a_ovf, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t3_ovf_clr", a_ovf, 0);

        // 4: enable low with valid pixels present
        clear_log();
        start_frame();
        send_run(1, 6);
        c0 = a_addr.size();
        en = 1'b0;
        valid = 1'b1;
        pixel = 24'd7;
        repeat (5) step();
        check("t4_frozen_writes", a_addr.size(), c0);
        check("t4_frozen_we", a_bram.we, 0);
        check("t4_busy", a_busy, 1);
        en = 1'b1;
        send_run(7, 6);
        wait_done("t4_done", 1);
        check("t4_count", a_addr.size(), 12);
        check_frame("t4", 6, 7);
        check("t4_ovf", a_ovf, 0);

        // 5: reset mid-frame
        clear_log();
        start_frame();
        send_run(1, 6);
        rst_n = 1'b0;
        step();
        check("t5_rst_we", a_bram.we, 0);
        check("t5_rst_flags", {a_busy, a_fd, a_ovf, a_pix.ready}, 4'b0001);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check("t5_no_done", a_done, 0);
        clear_log();
        start_frame();
        send_run(32'h20, 12);
        wait_done("t5_done", 1);
        check("t5_count", a_addr.size(), 12);
        check_frame("t5", 0, 32'h20);

        // 6: pixel outside a frame window, then a frame at base 0x100
        clear_log();
        step(); step();
        send_run(32'hABCDEF, 1);
        check("t6_ovf_early", b_ovf, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        start_frame();
        send_run(32'h300, 12);
        wait_done("t6_done", 1);
        check("t6_b_count", b_addr.size(), 12);
        if (b_addr.size() == 12) begin
            check("t6_b_first", b_addr[0], 32'h100);
            check("t6_b_last", b_addr[11], 32'h10B);
            check("t6_b_data", b_data[11], 32'h30B);
        end
        check("t6_b_range", b_bad, 0);
        check("a_range", a_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
